instr_encoder: RTL and testbench

Pipelined RISC-V instruction encoder: the inverse of the immediate-generation step in the decode path. It accepts decoded fields (format, registers, funct fields, 64-bit immediate) over a valid/ready handshake, range-checks the immediate, and packs a 32-bit instruction word. It tags each word with a sequential instruction-memory word address. It sits between the test/boot loader and instruction memory, so programs can be built from field records rather than hand-encoded words.

---
 rtl/rv_enc_pkg.sv | 38 +++
 rtl/instr_packer.sv | 75 +++++++
 rtl/instr_encoder.sv | 173 +++++++++++++++++
 tb/tb_instr_encoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared encodings for the RISC-V instruction encoder: opcodes, record formats,
// error codes and the immediate range helper.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtLoad = 3'd2,
    FmtS    = 3'd3,
    FmtB    = 3'd4,
    FmtJ    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrRange = 2'd1,
    ErrAlign = 2'd2,
    ErrFmt   = 2'd3
  } err_code_e;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJ    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] InstrNop = 32'h0000_0013;

  // True when imm[63:lsb] are all copies of the sign bit.
  function automatic logic imm_fits(logic [63:0] imm, int unsigned lsb);
    logic signed [63:0] t;
    t = $signed(imm) >>> lsb;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational field packer: builds the 32-bit word for a decoded record and
// flags illegal format, out-of-range immediates and misaligned branch offsets.
module instr_packer
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [63:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  logic [31:0] word;
  logic        fmt_ok;
  logic        range_ok;
  logic        align_ok;

  always_comb begin
    word     = '0;
    fmt_ok   = 1'b1;
    range_ok = 1'b1;
    align_ok = 1'b1;
    case (fmt_i)
      FmtR: begin
        word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OpR};
      end
      FmtI: begin
        word     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpImm};
        range_ok = imm_fits(imm_i, 11);
      end
      FmtLoad: begin
        word     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpLoad};
        range_ok = imm_fits(imm_i, 11);
      end
      FmtS: begin
        word     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OpS};
        range_ok = imm_fits(imm_i, 11);
      end
      FmtB: begin
        word     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OpB};
        range_ok = imm_fits(imm_i, 12);
        align_ok = ~imm_i[0];
      end
      FmtJ: begin
        word     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OpJ};
        range_ok = imm_fits(imm_i, 20);
        align_ok = ~imm_i[0];
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase
  end

  // Illegal format outranks a bad range, which outranks misalignment.
  always_comb begin
    err_code_o = ErrNone;
    if (!fmt_ok) begin
      err_code_o = ErrFmt;
    end else if (!range_ok) begin
      err_code_o = ErrRange;
    end else if (!align_ok) begin
      err_code_o = ErrAlign;
    end
  end

  assign err_o   = (err_code_o != ErrNone);
  assign instr_o = err_o ? InstrNop : word;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: packs field records into words, tags each with
// a sequential instruction-memory word address and hands them on over valid/ready.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [1:0]        out_err_code,
  output logic              full,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrLast = '1;

  logic [31:0] pk_instr;
  logic        pk_err;
  logic [1:0]  pk_err_code;

  instr_packer u_packer (
    .fmt_i      (in_fmt),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .imm_i      (in_imm),
    .instr_o    (pk_instr),
    .err_o      (pk_err),
    .err_code_o (pk_err_code)
  );

  logic              s1_valid_d, s1_valid_q;
  logic [31:0]       s1_instr_d, s1_instr_q;
  logic [ADDR_W-1:0] s1_addr_d, s1_addr_q;
  logic              s1_err_d, s1_err_q;
  logic [1:0]        s1_code_d, s1_code_q;

  logic              s2_valid_d, s2_valid_q;
  logic [31:0]       s2_instr_d, s2_instr_q;
  logic [ADDR_W-1:0] s2_addr_d, s2_addr_q;
  logic              s2_err_d, s2_err_q;
  logic [1:0]        s2_code_d, s2_code_q;

  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              full_d, full_q;
  logic              sticky_d, sticky_q;

  logic s2_free;
  logic s1_adv;
  logic accept;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !full_q && !start && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  // S1 captures the packed word together with the address it consumes.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_addr_d  = s1_addr_q;
    s1_err_d   = s1_err_q;
    s1_code_d  = s1_code_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_instr_d = pk_instr;
      s1_addr_d  = cnt_q;
      s1_err_d   = pk_err;
      s1_code_d  = pk_err_code;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 only reloads when free, so a stalled word stays put.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_addr_d  = s2_addr_q;
    s2_err_d   = s2_err_q;
    s2_code_d  = s2_code_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_instr_d = s1_instr_q;
      s2_addr_d  = s1_addr_q;
      s2_err_d   = s1_err_q;
      s2_code_d  = s1_code_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // The counter parks on the last address once it has been handed out.
  always_comb begin
    cnt_d    = cnt_q;
    full_d   = full_q;
    sticky_d = sticky_q;
    if (start) begin
      cnt_d    = AddrBase;
      full_d   = 1'b0;
      sticky_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == AddrLast) begin
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
      if (pk_err) begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_addr_q  <= AddrBase;
      s1_err_q   <= 1'b0;
      s1_code_q  <= ErrNone;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_addr_q  <= AddrBase;
      s2_err_q   <= 1'b0;
      s2_code_q  <= ErrNone;
      cnt_q      <= AddrBase;
      full_q     <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_addr_q  <= s1_addr_d;
      s1_err_q   <= s1_err_d;
      s1_code_q  <= s1_code_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_addr_q  <= s2_addr_d;
      s2_err_q   <= s2_err_d;
      s2_code_q  <= s2_code_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_instr    = s2_instr_q;
  assign out_addr     = s2_addr_q;
  assign out_err      = s2_err_q;
  assign out_err_code = s2_code_q;
  assign full         = full_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder plus a small ADDR_W=2 instance
// for address exhaustion, start and asynchronous reset.
module tb_instr_encoder;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    in_fmt, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [6:0]    in_funct7;
  logic [63:0]   in_imm;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err, full, err_sticky;
  logic [1:0]    out_err_code;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .out_err_code(out_err_code),
    .full(full), .err_sticky(err_sticky)
  );

  logic        s_rst_n, s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_out_instr;
  logic [1:0]  s_out_addr, s_out_err_code;
  logic        s_out_err, s_full, s_err_sticky;

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_fmt(3'd1), .in_rd(5'd1), .in_rs1(5'd2), .in_rs2(5'd0),
    .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(64'd7),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
    .out_addr(s_out_addr), .out_err(s_out_err), .out_err_code(s_out_err_code),
    .full(s_full), .err_sticky(s_err_sticky)
  );

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } rec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  exp_t        q[$];
  logic [31:0] h_instr[$];
  logic [63:0] h_addr[$];
  logic [1:0]  h_code[$];
  longint      m_addr;
  bit          m_full, m_err, check_lat;
  int          cyc, n_out;
  longint      bounds[16] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                              4094, -4098, 1048575, 1048576, -1048576, -1048577,
                              1048574, 0};

  function automatic logic [63:0] fld(logic [63:0] v, int hi, int lo);
    logic [63:0] m;
    m = (64'd1 << (hi - lo + 1)) - 64'd1;
    return (v >> lo) & m;
  endfunction

  function automatic exp_t model(rec_t r);
    exp_t        e;
    longint      simm, lim;
    logic [63:0] op, w, regs;
    int          code;
    simm = longint'(r.imm);
    code = 0;
    lim  = 0;
    op   = 0;
    case (r.fmt)
      3'd0: op = 64'h33;
      3'd1: begin op = 64'h13; lim = 2048; end
      3'd2: begin op = 64'h03; lim = 2048; end
      3'd3: begin op = 64'h23; lim = 2048; end
      3'd4: begin op = 64'h63; lim = 4096; end
      3'd5: begin op = 64'h6f; lim = 1048576; end
      default: code = 3;
    endcase
    if (code == 0 && lim != 0 && (simm < -lim || simm >= lim)) code = 1;
    else if (code == 0 && (r.fmt == 3'd4 || r.fmt == 3'd5) && r.imm[0]) code = 2;
    regs = (64'(r.rs1) << 15) | (64'(r.f3) << 12);
    case (r.fmt)
      3'd0: w = (64'(r.f7) << 25) | (64'(r.rs2) << 20) | regs | (64'(r.rd) << 7) | op;
      3'd1, 3'd2: w = (fld(r.imm, 11, 0) << 20) | regs | (64'(r.rd) << 7) | op;
      3'd3: w = (fld(r.imm, 11, 5) << 25) | (64'(r.rs2) << 20) | regs
                | (fld(r.imm, 4, 0) << 7) | op;
      3'd4: w = (fld(r.imm, 12, 12) << 31) | (fld(r.imm, 10, 5) << 25) | (64'(r.rs2) << 20)
                | regs | (fld(r.imm, 4, 1) << 8) | (fld(r.imm, 11, 11) << 7) | op;
      3'd5: w = (fld(r.imm, 20, 20) << 31) | (fld(r.imm, 10, 1) << 21)
                | (fld(r.imm, 11, 11) << 20) | (fld(r.imm, 19, 12) << 12)
                | (64'(r.rd) << 7) | op;
      default: w = 0;
    endcase
    e.instr = (code != 0) ? 32'h13 : w[31:0];
    e.err   = (code != 0);
    e.code  = 2'(code);
    e.addr  = 0;
    e.cyc   = 0;
    return e;
  endfunction

  function automatic rec_t mk(logic [2:0] fmt, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] f3, logic [6:0] f7, logic [63:0] imm);
    rec_t r;
    r.fmt = fmt; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t        r;
    logic [63:0] imm;
    case ($urandom_range(0, 2))
      0: imm = 64'(longint'($urandom_range(0, 10000)) - 5000);
      1: imm = 64'(bounds[$urandom_range(0, 15)]);
      default: imm = {$urandom, $urandom};
    endcase
    r = mk(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), imm);
    return r;
  endfunction

  task automatic drive(rec_t r);
    in_fmt = r.fmt; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
  endtask

  // Called at a falling edge with inputs driven; resolves the coming rising edge.
  task automatic step(output bit acc);
    exp_t e;
    rec_t r;
    #1;
    check("full", 64'(full), 64'(m_full));
    check("err_sticky", 64'(err_sticky), 64'(m_err));
    if (m_full) check("ready_when_full", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("instr", 64'(out_instr), 64'(e.instr));
        check("addr", 64'(out_addr), e.addr);
        check("err", 64'(out_err), 64'(e.err));
        check("err_code", 64'(out_err_code), 64'(e.code));
        if (check_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        h_instr.push_back(out_instr);
        h_addr.push_back(64'(out_addr));
        h_code.push_back(out_err_code);
        n_out++;
      end
    end
    acc = in_valid && in_ready;
    if (start) begin
      m_addr = 0;
      m_full = 0;
      m_err  = 0;
    end else if (acc) begin
      r = mk(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      e = model(r);
      e.addr = 64'(m_addr);
      e.cyc  = cyc;
      q.push_back(e);
      if (e.err) m_err = 1;
      if (m_addr == longint'((1 << AW) - 1)) m_full = 1;
      else m_addr++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(rec_t r);
    bit acc;
    bit done = 0;
    drive(r);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      step(acc);
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(int n);
    bit acc;
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  initial begin
    bit   acc;
    int   idx, n, out_before, s_acc, s_nout;
    bit   found;
    rec_t rb[4];
    rec_t r;

    rst_n = 0; start = 0; in_valid = 0; out_ready = 1; drive(mk(0, 0, 0, 0, 0, 0, 0));
    s_rst_n = 0; s_start = 0; s_in_valid = 0; s_out_ready = 1;
    m_addr = 0; m_full = 0; m_err = 0; cyc = 0; n_out = 0; check_lat = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_out_code", 64'(out_err_code), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_sticky", 64'(err_sticky), 64'd0);
    rst_n = 1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed words with exact two-cycle latency.
    check_lat = 1;
    send(mk(3'd1, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF));
    drain(3);
    n = h_instr.size();
    check("i_word", 64'(h_instr[n-1]), 64'hFFF0_8293);
    check("i_addr", h_addr[n-1], 64'd0);
    send(mk(3'd3, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 64'd8));
    send(mk(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC));
    drain(3);
    n = h_instr.size();
    check("s_word", 64'(h_instr[n-2]), 64'h0021_A423);
    check("b_word", 64'(h_instr[n-1]), 64'hFE00_0EE3);
    check("s_addr", h_addr[n-2], 64'd1);
    check("b_addr", h_addr[n-1], 64'd2);
    send(mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd5, 7'd0, 64'd2048));
    drain(3);
    n = h_instr.size();
    check("j_word", 64'(h_instr[n-1]), 64'h0010_00EF);
    check("pre_err_sticky", 64'(err_sticky), 64'd0);

    send(mk(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd2048));
    send(mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3));
    send(mk(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0));
    drain(3);
    n = h_instr.size();
    check("err_range_word", 64'(h_instr[n-3]), 64'h13);
    check("err_range_code", 64'(h_code[n-3]), 64'd1);
    check("err_align_code", 64'(h_code[n-2]), 64'd2);
    check("err_fmt_code", 64'(h_code[n-1]), 64'd3);
    check("err_fmt_addr", h_addr[n-1], 64'd6);
    check("err_sticky_set", 64'(err_sticky), 64'd1);
    check_lat = 0;

    // Backpressure: only two records fit behind a stalled output.
    for (int k = 0; k < 4; k++) rb[k] = rand_rec();
    out_ready = 0;
    idx = 0;
    out_before = n_out;
    for (int k = 0; k < 5; k++) begin
      if (idx < 4) begin drive(rb[idx]); in_valid = 1; end
      else in_valid = 0;
      step(acc);
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1;
    while (idx < 4) begin send(rb[idx]); idx++; end
    drain(4);
    check("bp_outputs", 64'(n_out - out_before), 64'd4);

    // Random traffic with stalls and occasional start pulses.
    for (int k = 0; k < 2000; k++) begin
      r = rand_rec();
      drive(r);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      start     = ($urandom_range(0, 63) == 0);
      step(acc);
    end
    start = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step(acc);
    check("drained", 64'(q.size()), 64'd0);

    // Small address space: exhaustion, start, async reset.
    s_rst_n = 1; s_in_valid = 1; s_acc = 0; s_nout = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (s_in_valid && s_in_ready) s_acc++;
      if (s_out_valid) begin
        check("small_addr", 64'(s_out_addr), 64'(s_nout));
        s_nout++;
      end
      @(negedge clk);
    end
    check("small_accepts", 64'(s_acc), 64'd4);
    check("small_outs", 64'(s_nout), 64'd4);
    check("small_full", 64'(s_full), 64'd1);
    check("small_ready_full", 64'(s_in_ready), 64'd0);
    s_start = 1;
    #1 check("small_ready_start", 64'(s_in_ready), 64'd0);
    @(negedge clk);
    s_start = 0;
    #1 check("small_full_clear", 64'(s_full), 64'd0);
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      #1;
      if (s_out_valid) begin
        found = 1;
        check("small_restart_addr", 64'(s_out_addr), 64'd0);
      end
    end
    if (!found) check("small_restart_timeout", 64'd0, 64'd1);
    #2;
    check("small_valid_before_rst", 64'(s_out_valid), 64'd1);
    s_rst_n = 0;
    #1;
    check("small_rst_valid", 64'(s_out_valid), 64'd0);
    check("small_rst_addr", 64'(s_out_addr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
